// File: rtl/alu_addr_sequencer_pkg.sv
// Shared CPU core definitions: ALU opcode map (also used by the decoder) and
// the address-sequencer state encoding.
package alu_addr_sequencer_pkg;

  localparam logic [5:0] OP_ADR0 = 6'b000000;  // low-byte add, captures carry
  localparam logic [5:0] OP_ADR1 = 6'b000001;  // high-byte add with ALU-held carry
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000100;
  localparam logic [5:0] OP_OR   = 6'b000101;
  localparam logic [5:0] OP_XOR  = 6'b000110;
  localparam logic [5:0] OP_ASL  = 6'b000111;
  localparam logic [5:0] OP_LSR  = 6'b001000;
  localparam logic [5:0] OP_ROL  = 6'b001001;
  localparam logic [5:0] OP_ROR  = 6'b001010;
  localparam logic [5:0] OP_PASS = 6'b001011;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_LO   = 2'd1,
    SEQ_HI   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_addr_sequencer_operand_mux.sv
// ALU operand/opcode select: decoder owns the ALU in IDLE, the address
// sequencer owns it in LO and HI.
module alu_operand_mux
  import alu_addr_sequencer_pkg::*;
#(
  parameter logic [5:0] ADR0_OP = OP_ADR0,
  parameter logic [5:0] ADR1_OP = OP_ADR1
) (
  input  seq_state_e  grant,
  input  logic [5:0]  dec_opcode,
  input  logic [7:0]  dec_a,
  input  logic [7:0]  dec_b,
  input  logic [7:0]  base_lo,
  input  logic [7:0]  base_hi,
  input  logic [7:0]  index,
  output logic [5:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    alu_opcode = dec_opcode;
    alu_a      = dec_a;
    alu_b      = dec_b;
    case (grant)
      SEQ_LO: begin
        alu_opcode = ADR0_OP;
        alu_a      = base_lo;
        alu_b      = index;
      end
      SEQ_HI: begin
        // The ALU folds in its own registered carry, so operand a is zero.
        alu_opcode = ADR1_OP;
        alu_a      = 8'h00;
        alu_b      = base_hi;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_addr_sequencer.sv
// Effective-address sequencer: drives the shared ALU through ADR0/ADR1 to form
// base + index, stalling the decoder while it owns the ALU.
module alu_addr_sequencer
  import alu_addr_sequencer_pkg::*;
#(
  parameter logic [5:0] ADR0_OP = OP_ADR0,
  parameter logic [5:0] ADR1_OP = OP_ADR1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_lo,
  input  logic [7:0] base_hi,
  input  logic [7:0] index,
  input  logic       zp_mode,
  input  logic       force_hi,
  input  logic [5:0] dec_opcode,
  input  logic [7:0] dec_a,
  input  logic [7:0] dec_b,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic [5:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] ea_lo,
  output logic [7:0] ea_hi,
  output logic       page_cross,
  output logic       busy,
  output logic       done
);

  seq_state_e state_q;
  logic [7:0] base_lo_q, base_hi_q, index_q;
  logic       zp_q, force_q, carry_q;
  logic [7:0] ea_lo_q, ea_hi_q;
  logic       page_cross_q, done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SEQ_IDLE;
      base_lo_q    <= 8'h00;
      base_hi_q    <= 8'h00;
      index_q      <= 8'h00;
      zp_q         <= 1'b0;
      force_q      <= 1'b0;
      carry_q      <= 1'b0;
      ea_lo_q      <= 8'h00;
      ea_hi_q      <= 8'h00;
      page_cross_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking default makes done a one-cycle pulse; a later assignment in the same edge wins.
      done_q <= 1'b0;
      case (state_q)
        SEQ_IDLE: begin
          if (start) begin
            base_lo_q <= base_lo;
            base_hi_q <= base_hi;
            index_q   <= index;
            zp_q      <= zp_mode;
            force_q   <= force_hi;
            state_q   <= SEQ_LO;
          end
        end
        SEQ_LO: begin
          ea_lo_q <= alu_out;
          carry_q <= alu_carry;
          if (zp_q) begin
            ea_hi_q      <= 8'h00;
            page_cross_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= SEQ_IDLE;
          end else if (alu_carry || force_q) begin
            state_q <= SEQ_HI;
          end else begin
            ea_hi_q      <= base_hi_q;
            page_cross_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= SEQ_IDLE;
          end
        end
        SEQ_HI: begin
          ea_hi_q      <= alu_out;
          page_cross_q <= carry_q;
          done_q       <= 1'b1;
          state_q      <= SEQ_IDLE;
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  alu_operand_mux #(
    .ADR0_OP (ADR0_OP),
    .ADR1_OP (ADR1_OP)
  ) u_mux (
    .grant      (state_q),
    .dec_opcode (dec_opcode),
    .dec_a      (dec_a),
    .dec_b      (dec_b),
    .base_lo    (base_lo_q),
    .base_hi    (base_hi_q),
    .index      (index_q),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b)
  );

  assign busy       = (state_q != SEQ_IDLE);
  assign ea_lo      = ea_lo_q;
  assign ea_hi      = ea_hi_q;
  assign page_cross = page_cross_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_addr_sequencer.sv
// Directed bench for alu_addr_sequencer with a behavioural ALU model and a
// scoreboard of expected completions checked by an independent monitor.
module tb_alu_addr_sequencer;

  localparam logic [5:0] ADR0 = 6'b000000;
  localparam logic [5:0] ADR1 = 6'b000001;
  localparam logic [5:0] DEC_OP = 6'b000010;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_lo, base_hi, index;
  logic       zp_mode, force_hi;
  logic [5:0] dec_opcode;
  logic [7:0] dec_a, dec_b;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic [5:0] alu_opcode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] ea_lo, ea_hi;
  logic       page_cross, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] ea;
    logic        pc;
    int          done_cyc;
  } exp_t;
  exp_t sb[$];

  alu_addr_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_lo    (base_lo),
    .base_hi    (base_hi),
    .index      (index),
    .zp_mode    (zp_mode),
    .force_hi   (force_hi),
    .dec_opcode (dec_opcode),
    .dec_a      (dec_a),
    .dec_b      (dec_b),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .ea_lo      (ea_lo),
    .ea_hi      (ea_hi),
    .page_cross (page_cross),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: ADR1 adds the carry it registered on the previous cycle.
  logic       alu_c_q = 1'b0;
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_opcode == ADR1) alu_sum = alu_sum + {8'h00, alu_c_q};
    alu_out   = alu_sum[7:0];
    alu_carry = alu_sum[8];
  end
  always @(posedge clk) alu_c_q <= alu_carry;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ea", {16'h0, ea_hi, ea_lo}, {16'h0, e.ea});
        check("page_cross", {31'h0, page_cross}, {31'h0, e.pc});
        check("done_latency", cyc, e.done_cyc);
        check("busy_at_done", {31'h0, busy}, 32'd0);
      end
    end
  end

  // Called just after a negedge; returns at the following negedge with start low.
  task automatic issue(input logic [15:0] base, input logic [7:0] idx, input logic zp,
                       input logic frc, input logic [15:0] exp_ea, input logic exp_pc,
                       input int lat);
    exp_t e;
    base_lo  = base[7:0];
    base_hi  = base[15:8];
    index    = idx;
    zp_mode  = zp;
    force_hi = frc;
    start    = 1'b1;
    e.ea       = exp_ea;
    e.pc       = exp_pc;
    e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n, (n < 20) ? n : 0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    base_lo = 8'h00; base_hi = 8'h00; index = 8'h00;
    zp_mode = 1'b0; force_hi = 1'b0;
    dec_opcode = DEC_OP; dec_a = 8'h12; dec_b = 8'h34;
    repeat (3) @(negedge clk);
    check("rst_ea", {16'h0, ea_hi, ea_lo}, 32'h0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_pc", {31'h0, page_cross}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Pass-through while idle
    check("pt_op", {26'h0, alu_opcode}, {26'h0, 6'b000010});
    check("pt_a", {24'h0, alu_a}, 32'h12);
    check("pt_b", {24'h0, alu_b}, 32'h34);
    dec_a = 8'hA5; dec_b = 8'h5A; #1;
    check("pt_a2", {24'h0, alu_a}, 32'hA5);
    check("pt_b2", {24'h0, alu_b}, 32'h5A);

    // No carry: single LO cycle
    issue(16'h1230, 8'h05, 1'b0, 1'b0, 16'h1235, 1'b0, 1);
    check("nc_lo_op", {26'h0, alu_opcode}, {26'h0, ADR0});
    check("nc_lo_a", {24'h0, alu_a}, 32'h30);
    check("nc_lo_b", {24'h0, alu_b}, 32'h05);
    check("nc_busy", {31'h0, busy}, 32'd1);
    drain();
    check("nc_idle_op", {26'h0, alu_opcode}, {26'h0, DEC_OP});

    // Page cross: LO then HI
    issue(16'h12F0, 8'h20, 1'b0, 1'b0, 16'h1310, 1'b1, 2);
    check("pc_lo_op", {26'h0, alu_opcode}, {26'h0, ADR0});
    @(negedge clk);
    check("pc_hi_op", {26'h0, alu_opcode}, {26'h0, ADR1});
    check("pc_hi_a", {24'h0, alu_a}, 32'h00);
    check("pc_hi_b", {24'h0, alu_b}, 32'h12);
    check("pc_hi_busy", {31'h0, busy}, 32'd1);
    drain();

    // Forced HI, wrap, zero page
    issue(16'h4000, 8'h01, 1'b0, 1'b1, 16'h4001, 1'b0, 2);
    drain();
    issue(16'hFFFF, 8'h01, 1'b0, 1'b0, 16'h0000, 1'b1, 2);
    drain();
    issue(16'h34F0, 8'h20, 1'b1, 1'b0, 16'h0010, 1'b0, 1);
    drain();

    // Start while busy is ignored
    issue(16'h12F0, 8'h20, 1'b0, 1'b0, 16'h1310, 1'b1, 2);
    check("ign_busy", {31'h0, busy}, 32'd1);
    base_lo = 8'h00; base_hi = 8'h77; index = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("ign_no_extra", {31'h0, busy}, 32'd0);

    // Back-to-back start on the done cycle
    issue(16'h2010, 8'h02, 1'b0, 1'b0, 16'h2012, 1'b0, 1);
    @(negedge clk);
    check("b2b_done", {31'h0, done}, 32'd1);
    issue(16'h50FF, 8'h01, 1'b0, 1'b0, 16'h5100, 1'b1, 2);
    drain();

    // Reset during HI aborts without done
    issue(16'h12F0, 8'h20, 1'b0, 1'b0, 16'h1310, 1'b1, 2);
    @(negedge clk);
    check("rh_in_hi", {26'h0, alu_opcode}, {26'h0, ADR1});
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rh_done", {31'h0, done}, 32'd0);
    check("rh_busy", {31'h0, busy}, 32'd0);
    check("rh_ea", {16'h0, ea_hi, ea_lo}, 32'h0);
    check("rh_pc", {31'h0, page_cross}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rh_no_done", {31'h0, done}, 32'd0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_addr_sequencer.md
Name: alu_addr_sequencer

Overview:
- Sequences the shared 8-bit ALU through its two-step address-add opcodes (ADR0, then ADR1) to form a 16-bit effective address from base + 8-bit index.
- Arbitrates ALU ownership between itself and the instruction decoder. The decoder's opcode/operands pass through when the sequencer is idle; the decoder is stalled while the sequencer owns the ALU.
- Sits between the decoder and the arithmetic unit in the CPU core.

Parameters:
- ADR0_OP, 6'b000000, ALU opcode for the low-byte add (captures carry).
- ADR1_OP, 6'b000001, ALU opcode for the high-byte add (ALU-registered carry + operand b).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request an address computation (sampled in IDLE only)
- base_lo  in  8  base address low byte
- base_hi  in  8  base address high byte
- index  in  8  X/Y index value
- zp_mode  in  1  zero-page indexed: high byte forced to 8'h00, carry discarded
- force_hi  in  1  always run the ADR1 cycle (write/RMW timing), even without carry
- dec_opcode  in  6  decoder's ALU opcode (pass-through when idle)
- dec_a  in  8  decoder's ALU operand a
- dec_b  in  8  decoder's ALU operand b
- alu_out  in  8  result from the ALU
- alu_carry  in  1  ALU flags_out[0]
- alu_opcode  out  6  opcode driven to the ALU
- alu_a  out  8  operand a driven to the ALU
- alu_b  out  8  operand b driven to the ALU
- ea_lo  out  8  effective address low byte (registered)
- ea_hi  out  8  effective address high byte (registered)
- page_cross  out  1  registered; 1 if the low-byte add carried (always 0 in zp_mode)
- busy  out  1  sequencer owns the ALU; decoder must stall
- done  out  1  one-cycle pulse; ea_lo/ea_hi/page_cross valid

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
  - On reset: state=IDLE; ea_lo=8'h00, ea_hi=8'h00, page_cross=0, done=0; busy=0.
  - Latched operands are cleared to 0.
  - Reset mid-operation aborts the sequence; no done pulse.
- FSM states: IDLE, LO, HI.
- IDLE:
  - ALU mux passes dec_opcode/dec_a/dec_b unchanged; busy=0.
  - start=1 latches base_lo, base_hi, index, zp_mode and force_hi, then goes to LO.
- LO:
  - Drive alu_opcode=ADR0_OP, alu_a=latched base_lo, alu_b=latched index; busy=1.
  - At the clock edge: ea_lo<=alu_out; carry_l<=alu_carry.
  - Next state:
    - zp_mode=1: go to IDLE with ea_hi<=8'h00, page_cross<=0, done<=1.
    - Else if alu_carry=1 or force_hi=1: go to HI.
    - Else: go to IDLE with ea_hi<=latched base_hi, page_cross<=0, done<=1.
- HI:
  - Drive alu_opcode=ADR1_OP, alu_a=8'h00, alu_b=latched base_hi; busy=1.
  - The ALU adds its own registered carry, so the sequencer does not drive carry.
  - At the clock edge: ea_hi<=alu_out, page_cross<=carry_l, done<=1; go to IDLE.
- Latency, with start sampled at edge T:
  - No HI cycle: LO during T..T+1, done high in cycle T+1..T+2.
  - With HI: done one cycle later.
  - busy is high exactly during LO/HI cycles.
- done:
  - A single-cycle pulse, deasserted automatically the next cycle.
  - ea_*/page_cross hold their values until the next completion or reset.
- start rules:
  - start while busy is ignored; no queueing.
  - start in the same cycle done is high (state IDLE) is accepted.
- Wrap-around:
  - base_hi=8'hFF with carry gives ea_hi=8'h00 and page_cross=1 (8-bit wrap, no error).
  - zp_mode wraps within page 0.
- Mux: alu_opcode/alu_a/alu_b are combinational from state and latches. There are no glitch requirements beyond single-driver.

Decomposition:
- Shared CPU package holds:
  - ALU opcode constants (ADR0/ADR1 and the full opcode list also used by the decoder).
  - The sequencer state enum.
- One natural sub-module: alu_operand_mux (grant-based 3-way select of opcode/a/b between decoder and sequencer). Everything else stays inline.

Test Plan:
- Pass-through: idle, dec_opcode=6'b000010, dec_a=8'h12, dec_b=8'h34 -> alu_* equal dec_* same cycle; busy=0.
- No carry: base=16'h1230, index=8'h05, force_hi=0 -> one LO cycle, done with ea=16'h1235, page_cross=0; alu_opcode=ADR0_OP only while busy.
- Page cross: base=16'h12F0, index=8'h20 -> LO then HI (ADR1_OP, alu_b=8'h12), done with ea=16'h1310, page_cross=1.
- Force/wrap/zp:
  - force_hi=1, base=16'h4000, index=8'h01 -> HI still runs; ea=16'h4001, page_cross=0.
  - base=16'hFFFF, index=8'h01 -> ea=16'h0000, page_cross=1.
  - zp_mode=1, base_lo=8'hF0, index=8'h20 -> ea=16'h0010, no HI cycle.
- Handshake/reset:
  - start while busy is ignored (results match the first request).
  - Back-to-back start on a done cycle is accepted.
  - reset during HI -> next cycle IDLE, done=0, ea=16'h0000, busy=0.
